sync_fifo: RTL and testbench

Registered synchronous FIFO datapath built around the combinational `fifo_ctrl` next-state logic. It holds the storage array, the write/read pointers and the occupancy count, and drives a registered read-data port. It sits between a producer stage that issues push requests and a consumer stage that issues pop requests, providing pipeline decoupling and rate buffering.

---
 rtl/sync_fifo_pkg.sv | 15 +
 rtl/sync_fifo_ctrl.sv | 56 +++++
 rtl/sync_fifo.sv | 96 +++++++++
 tb/tb_sync_fifo.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared FIFO constants: depth derivation and the push/pop operation encoding.
package sync_fifo_pkg;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  function automatic int fifo_depth(input int addr_bw);
    return 1 << addr_bw;
  endfunction

endpackage

// File: rtl/sync_fifo_ctrl.sv
// Combinational FIFO control: accept decisions, full/empty decode and next pointers/count.
// No state; everything here settles within the cycle ahead of the owning registers.
module fifo_ctrl
  import sync_fifo_pkg::*;
#(
  parameter int ADDR_BW = 2
) (
  input  logic [ADDR_BW-1:0] wr_ptr_i,
  input  logic [ADDR_BW-1:0] rd_ptr_i,
  input  logic [ADDR_BW:0]   num_item_i,
  input  logic               wr_din_i,
  input  logic               rd_dout_i,
  output logic [ADDR_BW-1:0] wr_ptr_d_o,
  output logic [ADDR_BW-1:0] rd_ptr_d_o,
  output logic [ADDR_BW:0]   num_item_d_o,
  output logic               push_o,
  output logic               pop_o,
  output logic               full_o,
  output logic               empty_o
);

  localparam logic [ADDR_BW:0] DEPTH = (ADDR_BW+1)'(fifo_depth(ADDR_BW));
  localparam logic [ADDR_BW-1:0] PTR_ONE = {{(ADDR_BW-1){1'b0}}, 1'b1};
  localparam logic [ADDR_BW:0] CNT_ONE = {{ADDR_BW{1'b0}}, 1'b1};

  fifo_op_e op;

  assign full_o  = (num_item_i == DEPTH);
  assign empty_o = (num_item_i == '0);
  // Accept decisions use the pre-edge flags, so full+push+pop drops the push.
  assign push_o  = wr_din_i & ~full_o;
  assign pop_o   = rd_dout_i & ~empty_o;
  assign op      = fifo_op_e'({push_o, pop_o});

  always_comb begin
    wr_ptr_d_o   = wr_ptr_i;
    rd_ptr_d_o   = rd_ptr_i;
    num_item_d_o = num_item_i;
    case (op)
      OP_PUSH: begin
        wr_ptr_d_o   = wr_ptr_i + PTR_ONE;
        num_item_d_o = num_item_i + CNT_ONE;
      end
      OP_POP: begin
        rd_ptr_d_o   = rd_ptr_i + PTR_ONE;
        num_item_d_o = num_item_i - CNT_ONE;
      end
      OP_BOTH: begin
        wr_ptr_d_o = wr_ptr_i + PTR_ONE;
        rd_ptr_d_o = rd_ptr_i + PTR_ONE;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/sync_fifo.sv
// Registered synchronous FIFO: storage, pointers, count, registered read port and sticky error flags.
// Pop-to-dout latency is one cycle; push and pop may both be accepted every cycle.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DATA_BW  = 8,
  parameter int ADDR_BW  = 2,
  parameter int AFULL_TH = (1 << ADDR_BW) - 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_din,
  input  logic [DATA_BW-1:0] din,
  input  logic               rd_dout,
  output logic [DATA_BW-1:0] dout,
  output logic               dout_valid,
  output logic               full,
  output logic               empty,
  output logic               afull,
  output logic [ADDR_BW:0]   num_item,
  output logic               ovf,
  output logic               udf
);

  localparam int DEPTH = fifo_depth(ADDR_BW);
  localparam logic [ADDR_BW:0] AFULL_W = (ADDR_BW+1)'(AFULL_TH);

  logic [ADDR_BW-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_BW-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_BW:0]   num_item_q, num_item_d;
  logic [DATA_BW-1:0] dout_q, dout_d;
  logic               dout_valid_q, dout_valid_d;
  logic               ovf_q, ovf_d;
  logic               udf_q, udf_d;
  logic               push, pop;
  logic [DATA_BW-1:0] mem_q [DEPTH];

  fifo_ctrl #(.ADDR_BW(ADDR_BW)) u_ctrl (
    .wr_ptr_i     (wr_ptr_q),
    .rd_ptr_i     (rd_ptr_q),
    .num_item_i   (num_item_q),
    .wr_din_i     (wr_din),
    .rd_dout_i    (rd_dout),
    .wr_ptr_d_o   (wr_ptr_d),
    .rd_ptr_d_o   (rd_ptr_d),
    .num_item_d_o (num_item_d),
    .push_o       (push),
    .pop_o        (pop),
    .full_o       (full),
    .empty_o      (empty)
  );

  always_comb begin
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    if (pop) begin
      dout_d       = mem_q[rd_ptr_q];
      dout_valid_d = 1'b1;
    end
    ovf_d = ovf_q | (wr_din & full);
    udf_d = udf_q | (rd_dout & empty);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      num_item_q   <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      ovf_q        <= 1'b0;
      udf_q        <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      num_item_q   <= num_item_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      ovf_q        <= ovf_d;
      udf_q        <= udf_d;
    end
  end

  // Storage is deliberately unreset; the count alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign num_item   = num_item_q;
  assign afull      = (num_item_q >= AFULL_W);
  assign ovf        = ovf_q;
  assign udf        = udf_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: directed scenarios then randomized traffic against a queue model.
module tb_sync_fifo;

  localparam int DEPTH = 4;
  localparam int AFULL = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_din;
  logic [7:0] din;
  logic       rd_dout;
  logic [7:0] dout;
  logic       dout_valid;
  logic       full;
  logic       empty;
  logic       afull;
  logic [2:0] num_item;
  logic       ovf;
  logic       udf;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] q_m[$];
  logic [7:0] dout_m;
  logic       dv_m;
  logic       ovf_m;
  logic       udf_m;

  sync_fifo dut (
    .clk        (clk),
    .rst        (rst),
    .wr_din     (wr_din),
    .din        (din),
    .rd_dout    (rd_dout),
    .dout       (dout),
    .dout_valid (dout_valid),
    .full       (full),
    .empty      (empty),
    .afull      (afull),
    .num_item   (num_item),
    .ovf        (ovf),
    .udf        (udf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q_m.delete();
    dout_m = 8'h00;
    dv_m   = 1'b0;
    ovf_m  = 1'b0;
    udf_m  = 1'b0;
  endtask

  task automatic check_all(input string ph);
    check({ph, ".dout"},       32'(dout),       32'(dout_m));
    check({ph, ".dout_valid"}, 32'(dout_valid), 32'(dv_m));
    check({ph, ".num_item"},   32'(num_item),   32'(q_m.size()));
    check({ph, ".full"},       32'(full),       32'(q_m.size() == DEPTH));
    check({ph, ".empty"},      32'(empty),      32'(q_m.size() == 0));
    check({ph, ".afull"},      32'(afull),      32'(q_m.size() >= AFULL));
    check({ph, ".ovf"},        32'(ovf),        32'(ovf_m));
    check({ph, ".udf"},        32'(udf),        32'(udf_m));
  endtask

  // Called at a falling edge; drives one cycle of requests and checks just after the rising edge.
  task automatic cycle(input string ph, input logic w, input logic [7:0] d, input logic r);
    bit was_full, was_empty;
    wr_din  = w;
    din     = d;
    rd_dout = r;
    was_full  = (q_m.size() == DEPTH);
    was_empty = (q_m.size() == 0);
    @(posedge clk);
    if (w && was_full)  ovf_m = 1'b1;
    if (r && was_empty) udf_m = 1'b1;
    if (r && !was_empty) begin
      dout_m = q_m.pop_front();
      dv_m   = 1'b1;
    end else begin
      dv_m = 1'b0;
    end
    if (w && !was_full) q_m.push_back(d);
    #1;
    check_all(ph);
    @(negedge clk);
    wr_din  = 1'b0;
    rd_dout = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wr_din = 1'b0; din = 8'h00; rd_dout = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    rst = 1'b0;

    cycle("push1", 1'b1, 8'h11, 1'b0);
    cycle("push2", 1'b1, 8'h22, 1'b0);
    cycle("push3", 1'b1, 8'h33, 1'b0);
    cycle("push4", 1'b1, 8'h44, 1'b0);
    cycle("push_full", 1'b1, 8'h99, 1'b0);
    for (int i = 0; i < 4; i++) cycle("drain", 1'b0, 8'h00, 1'b1);
    cycle("pop_empty", 1'b0, 8'h00, 1'b1);
    cycle("both_empty", 1'b1, 8'h5A, 1'b1);
    cycle("pop_5a", 1'b0, 8'h00, 1'b1);

    for (int i = 0; i < 4; i++) cycle("refill", 1'b1, 8'hA0 + 8'(i), 1'b0);
    cycle("both_full", 1'b1, 8'hEE, 1'b1);
    for (int i = 0; i < 3; i++) cycle("drain2", 1'b0, 8'h00, 1'b1);

    cycle("pre1", 1'b1, 8'h00, 1'b0);
    cycle("pre2", 1'b1, 8'h01, 1'b0);
    for (int i = 0; i < 20; i++) cycle("stream", 1'b1, 8'(8'h02 + i), 1'b1);
    cycle("to3", 1'b1, 8'h77, 1'b0);
    check("pre_arst.num_item", 32'(num_item), 32'd3);

    rst = 1'b1;
    #1;
    model_reset();
    check_all("arst");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 400; i++) begin
      logic w, r;
      w = ($urandom_range(0, 99) < 55);
      r = ($urandom_range(0, 99) < 50);
      cycle("rand", w, 8'($urandom), r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
